apb_interconnect_n: RTL and testbench

- Parametrised APB bridge and interconnect. Accepts single transactions from an upstream request/response port and decodes the address to one of NUM_SLV APB slaves.
- Runs a compliant APB4 SETUP/ACCESS sequence, honouring PREADY wait states, PSLVERR and PSTRB.
- Returns read data and an error flag upstream. Unmapped addresses and hung slaves complete with an error.
- Replaces the fixed 6-port, no-wait-state APB master/slave pair in the SoC peripheral subsystem.

---
 rtl/apb_interconnect_n_pkg.sv | 19 +
 rtl/apb_interconnect_n_if.sv | 50 +++++
 rtl/apb_interconnect_n_decoder.sv | 34 +++
 rtl/apb_interconnect_n.sv | 136 +++++++++++++
 tb/tb_apb_interconnect_n.sv | 392 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_interconnect_n_pkg.sv
// apb_ic_pkg
//   Shared types for the APB interconnect: the bridge FSM state encoding and
//   a helper that derives the slave-index width from the slave count.
//   No ports; imported by the interface users, decoder and top level.
package apb_ic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Width needed to index n slaves, never less than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/apb_interconnect_n_if.sv
// apb_interconnect_n_if
//   Bundles the upstream request/response port and the shared APB bus.
//   master modport: the bridge side (accepts requests, drives APB).
//   slave modport : the environment side (issues requests, models slaves).
//   Signals: req_valid/req_ready/req_addr/req_write/req_wdata/req_strb,
//            rsp_valid/rsp_rdata/rsp_err,
//            paddr/pwrite/pwdata/pstrb/penable/psel, prdata/pready/pslverr.
interface apb_interconnect_n_if #(
  parameter int NUM_SLV = 6,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic                      req_valid;
  logic                      req_ready;
  logic [ADDR_W-1:0]         req_addr;
  logic                      req_write;
  logic [DATA_W-1:0]         req_wdata;
  logic [STRB_W-1:0]         req_strb;

  logic                      rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_err;

  logic [ADDR_W-1:0]         paddr;
  logic                      pwrite;
  logic [DATA_W-1:0]         pwdata;
  logic [STRB_W-1:0]         pstrb;
  logic                      penable;
  logic [NUM_SLV-1:0]        psel;
  logic [NUM_SLV*DATA_W-1:0] prdata;
  logic [NUM_SLV-1:0]        pready;
  logic [NUM_SLV-1:0]        pslverr;

  modport master (
    input  req_valid, req_addr, req_write, req_wdata, req_strb,
    input  prdata, pready, pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output paddr, pwrite, pwdata, pstrb, penable, psel
  );

  modport slave (
    output req_valid, req_addr, req_write, req_wdata, req_strb,
    output prdata, pready, pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  paddr, pwrite, pwdata, pstrb, penable, psel
  );

endinterface

// File: rtl/apb_interconnect_n_decoder.sv
// apb_ic_decoder
//   Combinational address decoder. The top IDX_W address bits select a slave.
//   Ports:
//     addr : request address
//     idx  : decoded slave index
//     sel  : one-hot select (all zero on a miss)
//     hit  : index maps to an existing slave
module apb_ic_decoder
  import apb_ic_pkg::*;
#(
  parameter int NUM_SLV = 6,
  parameter int ADDR_W  = 12,
  parameter int IDX_W   = idx_width(NUM_SLV)
) (
  input  logic [ADDR_W-1:0]  addr,
  output logic [IDX_W-1:0]   idx,
  output logic [NUM_SLV-1:0] sel,
  output logic               hit
);

  // Low address bits are the offset within a slave and play no part here.
  logic unused_low_bits;
  assign unused_low_bits = ^addr[ADDR_W-IDX_W-1:0];

  assign idx = addr[ADDR_W-1 -: IDX_W];

  // When NUM_SLV is not a power of two the upper index codes are unmapped.
  always_comb begin
    sel = '0;
    hit = (int'(idx) < NUM_SLV);
    if (hit) sel[idx] = 1'b1;
  end

endmodule

// File: rtl/apb_interconnect_n.sv
// apb_interconnect_n
//   Single-outstanding bridge from a valid/ready request port to NUM_SLV APB4
//   slaves. Runs SETUP/ACCESS, honours wait states and PSLVERR, aborts hung
//   slaves after TIMEOUT access cycles and reports decode misses as errors.
//   Ports:
//     clk : rising-edge clock
//     rst : synchronous active-high reset
//     bus : apb_interconnect_n_if master modport (request, response, APB)
module apb_interconnect_n
  import apb_ic_pkg::*;
#(
  parameter int NUM_SLV = 6,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int IDX_W   = idx_width(NUM_SLV),
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  apb_interconnect_n_if.master bus
);

  // The counter only has to reach TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t              state;
  logic [IDX_W-1:0]    cur_idx;
  logic [CNT_W-1:0]    wait_cnt;

  logic [IDX_W-1:0]    dec_idx;
  logic [NUM_SLV-1:0]  dec_sel;
  logic                dec_hit;

  logic [DATA_W-1:0]   sel_rdata;
  logic                sel_ready;
  logic                sel_err;
  logic                timeout_hit;

  apb_ic_decoder #(
    .NUM_SLV (NUM_SLV),
    .ADDR_W  (ADDR_W),
    .IDX_W   (IDX_W)
  ) u_decoder (
    .addr (bus.req_addr),
    .idx  (dec_idx),
    .sel  (dec_sel),
    .hit  (dec_hit)
  );

  // Only the latched slave's return signals are ever looked at.
  assign sel_rdata = bus.prdata[int'(cur_idx) * DATA_W +: DATA_W];
  assign sel_ready = bus.pready[cur_idx];
  assign sel_err   = bus.pslverr[cur_idx];

  assign timeout_hit = (TIMEOUT > 0) && (wait_cnt == CNT_W'(TIMEOUT - 1));

  // Gated by rst so nothing is accepted while reset is held.
  assign bus.req_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cur_idx       <= '0;
      wait_cnt      <= '0;
      bus.psel      <= '0;
      bus.penable   <= 1'b0;
      bus.paddr     <= '0;
      bus.pwrite    <= 1'b0;
      bus.pwdata    <= '0;
      bus.pstrb     <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      // rsp_valid is raised only on the transition into RESP.
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            bus.paddr     <= bus.req_addr;
            bus.pwrite    <= bus.req_write;
            bus.pwdata    <= bus.req_write ? bus.req_wdata : '0;
            bus.pstrb     <= bus.req_write ? bus.req_strb  : '0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            wait_cnt      <= '0;
            if (dec_hit) begin
              cur_idx  <= dec_idx;
              bus.psel <= dec_sel;
              state    <= SETUP;
            end else begin
              bus.rsp_err   <= 1'b1;
              bus.rsp_valid <= 1'b1;
              state         <= RESP;
            end
          end
        end

        SETUP: begin
          bus.penable <= 1'b1;
          state       <= ACCESS;
        end

        ACCESS: begin
          // pready wins over the timeout on the last permitted cycle.
          if (sel_ready) begin
            bus.psel      <= '0;
            bus.penable   <= 1'b0;
            bus.rsp_err   <= sel_err;
            bus.rsp_rdata <= (!bus.pwrite && !sel_err) ? sel_rdata : '0;
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
          end else if (timeout_hit) begin
            bus.psel      <= '0;
            bus.penable   <= 1'b0;
            bus.rsp_err   <= 1'b1;
            bus.rsp_rdata <= '0;
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        RESP: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_interconnect_n.sv
// tb_apb_interconnect_n
//   Self-checking bench: slave models with configurable wait states, error
//   and read data; a reference model predicts latency, access cycles and the
//   response from the address map and slave configuration.
module tb_apb_interconnect_n;
  import apb_ic_pkg::*;

  localparam int NUM_SLV = 6;
  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;
  localparam int SLOT    = 1 << (ADDR_W - idx_width(NUM_SLV));

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apb_interconnect_n_if #(.NUM_SLV(NUM_SLV), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  apb_interconnect_n #(
    .NUM_SLV (NUM_SLV),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int passes = 0;

  // Slave configuration and behaviour.
  int unsigned       wait_cfg  [NUM_SLV];
  logic              err_cfg   [NUM_SLV];
  logic [DATA_W-1:0] rdata_cfg [NUM_SLV];
  int unsigned       acc_cnt   [NUM_SLV];
  logic [NUM_SLV-1:0] noise_ready;
  logic [NUM_SLV-1:0] noise_err;

  always @(posedge clk) begin
    for (int i = 0; i < NUM_SLV; i++)
      acc_cnt[i] <= (bus.psel[i] && bus.penable) ? acc_cnt[i] + 1 : 0;
  end

  always @(negedge clk) begin
    noise_ready <= NUM_SLV'($urandom);
    noise_err   <= NUM_SLV'($urandom);
  end

  // Unselected slaves drive random pready/pslverr to show they are ignored.
  always_comb begin
    bus.pready  = '0;
    bus.pslverr = '0;
    bus.prdata  = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      bus.prdata[i*DATA_W +: DATA_W] = rdata_cfg[i];
      if (bus.psel[i] && bus.penable) begin
        bus.pready[i]  = (acc_cnt[i] >= wait_cfg[i]);
        bus.pslverr[i] = err_cfg[i];
      end else begin
        bus.pready[i]  = noise_ready[i];
        bus.pslverr[i] = noise_err[i];
      end
    end
  end

  typedef struct {
    bit                 accepted;
    int                 lat;
    int                 access;
    logic               err;
    logic [DATA_W-1:0]  rdata;
    logic [NUM_SLV-1:0] first_psel;
    logic               first_penable;
    logic               second_penable;
    logic [NUM_SLV-1:0] psel_seen;
    logic [NUM_SLV-1:0] psel_at_rsp;
    logic               rsp_after;
    bit                 stable_ok;
    bit                 onehot_ok;
  } txn_obs_t;

  // Reference model: address slots map to slaves; a slave with w wait states
  // answers after w+1 access cycles unless w reaches the timeout.
  function automatic void model(input logic [ADDR_W-1:0] addr, input logic wr,
                                output int lat, output int acc, output logic err,
                                output logic [DATA_W-1:0] rd, output logic [NUM_SLV-1:0] sel);
    int s;
    s = int'(addr) / SLOT;
    if (s >= NUM_SLV) begin
      lat = 1; acc = 0; err = 1'b1; rd = '0; sel = '0;
      return;
    end
    sel = NUM_SLV'(1 << s);
    if (TIMEOUT > 0 && wait_cfg[s] >= TIMEOUT) begin
      acc = TIMEOUT; lat = 2 + TIMEOUT; err = 1'b1; rd = '0;
    end else begin
      acc = int'(wait_cfg[s]) + 1;
      lat = 3 + int'(wait_cfg[s]);
      err = err_cfg[s];
      rd  = (wr || err) ? '0 : rdata_cfg[s];
    end
  endfunction

  // Drives one request and records what the bus did until the response.
  task automatic do_txn(input logic [ADDR_W-1:0] addr, input logic wr,
                        input logic [DATA_W-1:0] wd, input logic [3:0] st,
                        output txn_obs_t o);
    bit acc;
    o = '{default: '0};
    o.lat = -1;
    o.stable_ok = 1'b1;
    o.onehot_ok = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_write = wr;
    bus.req_wdata = wd;
    bus.req_strb  = st;
    acc = 1'b0;
    for (int k = 0; k < 40; k++) begin
      acc = bus.req_ready;
      @(posedge clk);
      if (acc) break;
      @(negedge clk);
    end
    #1 bus.req_valid = 1'b0;
    o.accepted = acc;
    if (!acc) return;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (k == 0) begin
        o.first_psel    = bus.psel;
        o.first_penable = bus.penable;
      end
      if (k == 1) o.second_penable = bus.penable;
      o.psel_seen |= bus.psel;
      if (bus.psel != 0 && bus.penable) o.access++;
      if ($countones(bus.psel) > 1 || (bus.penable && bus.psel == 0)) o.onehot_ok = 1'b0;
      if (bus.psel != 0 && (bus.paddr !== addr || bus.pwrite !== wr ||
          bus.pwdata !== (wr ? wd : '0) || bus.pstrb !== (wr ? st : 4'h0)))
        o.stable_ok = 1'b0;
      if (bus.rsp_valid) begin
        o.lat         = k + 1;
        o.rdata       = bus.rsp_rdata;
        o.err         = bus.rsp_err;
        o.psel_at_rsp = bus.psel;
        break;
      end
      @(posedge clk);
    end
    @(negedge clk);
    o.rsp_after = bus.rsp_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 12'h404;
    bus.req_write = 1'b1;
    bus.req_wdata = 32'hFFFF_FFFF;
    bus.req_strb  = 4'hF;
    repeat (3) @(negedge clk);
    checks++; if (bus.psel !== 6'b0) $display("[TB] FAIL reset_psel: got %b want 0", bus.psel); else passes++;
    checks++; if (bus.penable !== 1'b0) $display("[TB] FAIL reset_penable: got %b want 0", bus.penable); else passes++;
    checks++; if (bus.rsp_valid !== 1'b0) $display("[TB] FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); else passes++;
    checks++; if ({bus.paddr, bus.pwrite, bus.pwdata, bus.pstrb} !== '0)
      $display("[TB] FAIL reset_apb_fields: got %h/%b/%h/%h want 0", bus.paddr, bus.pwrite, bus.pwdata, bus.pstrb); else passes++;
    checks++; if ({bus.rsp_rdata, bus.rsp_err} !== '0)
      $display("[TB] FAIL reset_rsp_fields: got %h/%b want 0", bus.rsp_rdata, bus.rsp_err); else passes++;
    checks++; if (bus.req_ready !== 1'b0) $display("[TB] FAIL reset_req_ready: got %b want 0", bus.req_ready); else passes++;
    bus.req_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 1'b1) $display("[TB] FAIL post_reset_ready: got %b want 1", bus.req_ready); else passes++;
    @(negedge clk);
    checks++; if (bus.psel !== 6'b0) $display("[TB] FAIL post_reset_psel: got %b want 0", bus.psel); else passes++;
  endtask

  task automatic test_zero_wait_write();
    txn_obs_t o;
    wait_cfg[2] = 0; err_cfg[2] = 1'b0;
    do_txn(12'h404, 1'b1, 32'hDEAD_BEEF, 4'hF, o);
    checks++; if (o.accepted !== 1'b1) $display("[TB] FAIL zw_accept: got %b want 1", o.accepted); else passes++;
    checks++; if (o.first_psel !== 6'b000100) $display("[TB] FAIL zw_setup_psel: got %b want 000100", o.first_psel); else passes++;
    checks++; if (o.first_penable !== 1'b0) $display("[TB] FAIL zw_setup_penable: got %b want 0", o.first_penable); else passes++;
    checks++; if (o.second_penable !== 1'b1) $display("[TB] FAIL zw_access_penable: got %b want 1", o.second_penable); else passes++;
    checks++; if (o.lat !== 3) $display("[TB] FAIL zw_latency: got %0d want 3", o.lat); else passes++;
    checks++; if (o.err !== 1'b0) $display("[TB] FAIL zw_err: got %b want 0", o.err); else passes++;
    checks++; if (o.rdata !== 32'h0) $display("[TB] FAIL zw_rdata: got %h want 0", o.rdata); else passes++;
    checks++; if (o.stable_ok !== 1'b1) $display("[TB] FAIL zw_apb_fields: got %b want 1", o.stable_ok); else passes++;
    checks++; if (o.rsp_after !== 1'b0) $display("[TB] FAIL zw_rsp_pulse: got %b want 0", o.rsp_after); else passes++;
  endtask

  task automatic test_read_wait();
    txn_obs_t o;
    wait_cfg[1] = 3; err_cfg[1] = 1'b0; rdata_cfg[1] = 32'h1234_5678;
    do_txn(12'h210, 1'b0, 32'hA5A5_A5A5, 4'hF, o);
    checks++; if (o.lat !== 6) $display("[TB] FAIL rw_latency: got %0d want 6", o.lat); else passes++;
    checks++; if (o.access !== 4) $display("[TB] FAIL rw_access_cycles: got %0d want 4", o.access); else passes++;
    checks++; if (o.rdata !== 32'h1234_5678) $display("[TB] FAIL rw_rdata: got %h want 12345678", o.rdata); else passes++;
    checks++; if (o.err !== 1'b0) $display("[TB] FAIL rw_err: got %b want 0", o.err); else passes++;
    checks++; if (o.stable_ok !== 1'b1) $display("[TB] FAIL rw_stable_zero_strb: got %b want 1", o.stable_ok); else passes++;
  endtask

  task automatic test_decode_error();
    txn_obs_t o;
    logic [ADDR_W-1:0] addrs [2];
    addrs[0] = 12'hC00;
    addrs[1] = 12'hE7C;
    for (int i = 0; i < 2; i++) begin
      do_txn(addrs[i], 1'b0, '0, 4'h0, o);
      checks++; if (o.psel_seen !== 6'b0) $display("[TB] FAIL dec_psel[%0d]: got %b want 0", i, o.psel_seen); else passes++;
      checks++; if (o.lat !== 1) $display("[TB] FAIL dec_latency[%0d]: got %0d want 1", i, o.lat); else passes++;
      checks++; if ({o.err, o.rdata} !== {1'b1, 32'h0}) $display("[TB] FAIL dec_rsp[%0d]: got %b/%h want 1/0", i, o.err, o.rdata); else passes++;
    end
  endtask

  task automatic test_slave_error();
    txn_obs_t o;
    wait_cfg[0] = 0; err_cfg[0] = 1'b1; rdata_cfg[0] = 32'hCAFE_F00D;
    do_txn(12'h01C, 1'b0, '0, 4'h0, o);
    checks++; if (o.err !== 1'b1) $display("[TB] FAIL slverr_read_err: got %b want 1", o.err); else passes++;
    checks++; if (o.lat !== 3) $display("[TB] FAIL slverr_latency: got %0d want 3", o.lat); else passes++;
    do_txn(12'h020, 1'b1, 32'h0BAD_0BAD, 4'h3, o);
    checks++; if (o.err !== 1'b1) $display("[TB] FAIL slverr_write_err: got %b want 1", o.err); else passes++;
    err_cfg[0] = 1'b0;
  endtask

  task automatic test_timeout();
    txn_obs_t o;
    wait_cfg[5] = 1000; err_cfg[5] = 1'b0; rdata_cfg[5] = 32'h5555_AAAA;
    do_txn(12'hA08, 1'b0, '0, 4'h0, o);
    checks++; if (o.access !== 16) $display("[TB] FAIL to_access_cycles: got %0d want 16", o.access); else passes++;
    checks++; if (o.lat !== 18) $display("[TB] FAIL to_latency: got %0d want 18", o.lat); else passes++;
    checks++; if ({o.err, o.rdata} !== {1'b1, 32'h0}) $display("[TB] FAIL to_rsp: got %b/%h want 1/0", o.err, o.rdata); else passes++;
    checks++; if (o.psel_at_rsp !== 6'b0) $display("[TB] FAIL to_psel_dropped: got %b want 0", o.psel_at_rsp); else passes++;
    // Ready on the last permitted access cycle is a normal completion.
    wait_cfg[5] = TIMEOUT - 1;
    do_txn(12'hA08, 1'b0, '0, 4'h0, o);
    checks++; if (o.access !== 16) $display("[TB] FAIL edge_access_cycles: got %0d want 16", o.access); else passes++;
    checks++; if ({o.err, o.rdata} !== {1'b0, 32'h5555_AAAA}) $display("[TB] FAIL edge_rsp: got %b/%h want 0/5555aaaa", o.err, o.rdata); else passes++;
    wait_cfg[5] = 0;
  endtask

  task automatic test_reset_mid_access();
    txn_obs_t o;
    int n_access;
    bit acc;
    bit saw_rsp;
    wait_cfg[3] = 1000;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = 12'h600;
    bus.req_write = 1'b0;
    bus.req_wdata = '0;
    bus.req_strb  = 4'h0;
    acc = 1'b0;
    for (int k = 0; k < 10 && !acc; k++) begin
      acc = bus.req_ready;
      @(posedge clk);
      if (!acc) @(negedge clk);
    end
    #1 bus.req_valid = 1'b0;
    n_access = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.psel != 0 && bus.penable) n_access++;
      if (n_access == 2) break;
    end
    checks++; if (n_access !== 2) $display("[TB] FAIL rma_reach_access: got %0d want 2", n_access); else passes++;
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({bus.psel, bus.penable} !== 7'b0) $display("[TB] FAIL rma_apb_dropped: got %b/%b want 0", bus.psel, bus.penable); else passes++;
    checks++; if ({bus.paddr, bus.rsp_valid, bus.rsp_err} !== '0)
      $display("[TB] FAIL rma_outputs_zero: got %h/%b/%b want 0", bus.paddr, bus.rsp_valid, bus.rsp_err); else passes++;
    rst = 1'b0;
    wait_cfg[3] = 0;
    #1;
    checks++; if (bus.req_ready !== 1'b1) $display("[TB] FAIL rma_ready: got %b want 1", bus.req_ready); else passes++;
    saw_rsp = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.rsp_valid) saw_rsp = 1'b1;
    end
    checks++; if (saw_rsp !== 1'b0) $display("[TB] FAIL rma_no_response: got %b want 0", saw_rsp); else passes++;
    wait_cfg[4] = 0; err_cfg[4] = 1'b0;
    do_txn(12'h810, 1'b1, 32'h0102_0304, 4'hC, o);
    checks++; if ({o.lat, o.err} !== {32'd3, 1'b0}) $display("[TB] FAIL rma_fresh_write: got lat %0d err %b want 3/0", o.lat, o.err); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] q_addr [3];
    logic [DATA_W-1:0] exp_rd [3];
    int acc_cyc [3];
    logic [DATA_W-1:0] got_rd [3];
    logic got_err [3];
    int nacc, nrsp;
    bit will_acc, overlap;
    q_addr[0] = 12'h004; q_addr[1] = 12'h608; q_addr[2] = 12'hA0C;
    wait_cfg[0] = 0; wait_cfg[3] = 0; wait_cfg[5] = 0;
    err_cfg[0] = 1'b0; err_cfg[3] = 1'b0; err_cfg[5] = 1'b0;
    rdata_cfg[0] = $urandom; rdata_cfg[3] = $urandom; rdata_cfg[5] = $urandom;
    exp_rd[0] = rdata_cfg[0]; exp_rd[1] = rdata_cfg[3]; exp_rd[2] = rdata_cfg[5];
    nacc = 0; nrsp = 0; overlap = 1'b0;
    for (int i = 0; i < 3; i++) begin acc_cyc[i] = -100; got_rd[i] = 'x; got_err[i] = 1'bx; end
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_addr = q_addr[0]; bus.req_write = 1'b0;
    bus.req_wdata = '0; bus.req_strb = 4'h0;
    for (int c = 0; c < 80 && nrsp < 3; c++) begin
      will_acc = bus.req_valid && bus.req_ready;
      @(posedge clk);
      if (will_acc) begin acc_cyc[nacc] = c; nacc++; end
      @(negedge clk);
      if ($countones(bus.psel) > 1) overlap = 1'b1;
      if (bus.rsp_valid) begin got_rd[nrsp] = bus.rsp_rdata; got_err[nrsp] = bus.rsp_err; nrsp++; end
      if (will_acc) begin
        if (nacc < 3) bus.req_addr = q_addr[nacc];
        else bus.req_valid = 1'b0;
      end
    end
    bus.req_valid = 1'b0;
    checks++; if (acc_cyc[1] - acc_cyc[0] !== 4) $display("[TB] FAIL b2b_gap01: got %0d want 4", acc_cyc[1] - acc_cyc[0]); else passes++;
    checks++; if (acc_cyc[2] - acc_cyc[1] !== 4) $display("[TB] FAIL b2b_gap12: got %0d want 4", acc_cyc[2] - acc_cyc[1]); else passes++;
    checks++; if (overlap !== 1'b0) $display("[TB] FAIL b2b_psel_overlap: got %b want 0", overlap); else passes++;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({got_err[i], got_rd[i]} !== {1'b0, exp_rd[i]})
        $display("[TB] FAIL b2b_rsp[%0d]: got %b/%h want 0/%h", i, got_err[i], got_rd[i], exp_rd[i]); else passes++;
    end
  endtask

  task automatic test_random();
    txn_obs_t o;
    logic [ADDR_W-1:0] addr;
    logic wr;
    logic [DATA_W-1:0] wd;
    logic [3:0] st;
    int s, e_lat, e_acc;
    logic e_err;
    logic [DATA_W-1:0] e_rd;
    logic [NUM_SLV-1:0] e_sel;
    for (int n = 0; n < 40; n++) begin
      addr = ADDR_W'($urandom);
      wr   = 1'($urandom);
      wd   = $urandom;
      st   = 4'($urandom);
      s    = int'(addr) / SLOT;
      if (s < NUM_SLV) begin
        wait_cfg[s]  = ($urandom_range(0, 7) == 0) ? 30 : $urandom_range(0, 4);
        err_cfg[s]   = ($urandom_range(0, 3) == 0);
        rdata_cfg[s] = $urandom;
      end
      model(addr, wr, e_lat, e_acc, e_err, e_rd, e_sel);
      do_txn(addr, wr, wd, st, o);
      checks++; if (o.lat !== e_lat) $display("[TB] FAIL rand_lat[%0d]: got %0d want %0d", n, o.lat, e_lat); else passes++;
      checks++; if (o.access !== e_acc) $display("[TB] FAIL rand_access[%0d]: got %0d want %0d", n, o.access, e_acc); else passes++;
      checks++; if ({o.err, o.rdata} !== {e_err, e_rd})
        $display("[TB] FAIL rand_rsp[%0d]: got %b/%h want %b/%h", n, o.err, o.rdata, e_err, e_rd); else passes++;
      checks++; if (o.psel_seen !== e_sel) $display("[TB] FAIL rand_psel[%0d]: got %b want %b", n, o.psel_seen, e_sel); else passes++;
      checks++; if ({o.stable_ok, o.onehot_ok} !== 2'b11)
        $display("[TB] FAIL rand_protocol[%0d]: got %b%b want 11", n, o.stable_ok, o.onehot_ok); else passes++;
    end
  endtask

  initial begin
    for (int i = 0; i < NUM_SLV; i++) begin
      wait_cfg[i]  = 0;
      err_cfg[i]   = 1'b0;
      rdata_cfg[i] = $urandom;
    end
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_write = 1'b0;
    bus.req_wdata = '0;
    bus.req_strb  = '0;
    $display("[TB] starting apb_interconnect_n bench");
    test_reset();
    test_zero_wait_write();
    test_read_wait();
    test_decode_error();
    test_slave_error();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
